muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Iterative signed MULT/DIV engine with its own sequencer and HI/LO registers.
//  Runs one 32-step shift-add multiply or restoring divide per request.
//  Sits beside the ALU. The control unit pulses start from its MULT/DIV states and
//  holds those states until done. MFHI/MFLO read hi/lo directly.
// PARAMETERS
//  WIDTH  32  operand width; iteration count = WIDTH; HI/LO each WIDTH bits
// PORTS
//  clk        in   1        clock
//  reset      in   1        synchronous, active-high
//  start      in   1        request; sampled only in IDLE
//  op         in   1        0 = MULT, 1 = DIV
//  operand_a  in   WIDTH    rs value (multiplicand / dividend), signed
//  operand_b  in   WIDTH    rt value (multiplier / divisor), signed
//  busy       out  1        high in RUN and FINISH
//  done       out  1        one-cycle pulse; hi/lo valid from this cycle on
//  div_zero   out  1        one-cycle pulse coincident with done; DIV with b==0
//  hi         out  WIDTH    MULT: product[2W-1:W]; DIV: remainder
//  lo         out  WIDTH    MULT: product[W-1:0];  DIV: quotient
// BEHAVIOUR
//  - Reset (clk edge with reset=1): state=IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0,
//    step counter=0. Applies mid-operation: the operation is aborted and no done is issued.
//  - States:
//    - IDLE -> RUN when start=1 and not DIV-by-zero.
//    - IDLE -> IDLE with done=1, div_zero=1 when start=1, op=1, b==0. hi/lo unchanged.
//    - RUN: WIDTH cycles, counter WIDTH-1 down to 0, then -> FINISH.
//    - FINISH: sign fix, write hi/lo, -> IDLE with done=1 on the next cycle.
//  - Latency: start accepted at edge T; done=1 and hi/lo updated in the cycle after edge
//    T+WIDTH+1 (34 cycles for WIDTH=32). DIV-by-zero: done in the cycle after edge T.
//  - Operand capture: on acceptance, latch |a|, |b| and the sign bits. Later input
//    changes are ignored.
//    - abs(-2^(W-1)) = 2^(W-1) as unsigned; no overflow.
//  - MULT: unsigned shift-add over a 2W-bit accumulator. If sign(a)^sign(b), FINISH applies
//    two's-complement negate of the full 2W result.
//  - DIV: restoring, one quotient bit per cycle (W+1-bit partial remainder).
//    - quotient sign = sign(a)^sign(b); remainder sign = sign(a).
//    - -2^(W-1) / -1 gives lo=0x8000_0000, hi=0 (defined wrap, no trap).
//  - start while busy: ignored, no queueing.
//    - start in the same cycle as done (state IDLE) is accepted normally.
//  - done and div_zero are never high for two consecutive cycles from one request.
//  - hi/lo change only in FINISH, on the div-by-zero path (no change), or on reset.
// STRUCTURE
//  - muldiv_pkg: state typedef {IDLE, RUN, FINISH}; OP_MULT=1'b0, OP_DIV=1'b1; WIDTH default.
//  - Sub-module muldiv_step: combinational single iteration. Inputs: op, accumulator,
//    operand. Outputs: next accumulator and quotient bit.
//  - The sequencer owns the FSM, counter, sign latches and the hi/lo registers.
// TESTING
//  1. MULT a=7, b=-3 -> done at cycle 34; hi=0xFFFF_FFFF, lo=0xFFFF_FFEB, div_zero=0.
//  2. DIV a=-17, b=5 -> lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFE (-2); busy high 33 cycles.
//  3. DIV a=9, b=0 with prior hi/lo=0x1234/0x5678 -> next cycle done=1, div_zero=1,
//     hi/lo unchanged.
//  4. MULT 0x8000_0000 x 0x8000_0000 -> hi=0x4000_0000, lo=0. DIV 0x8000_0000 / -1 ->
//     lo=0x8000_0000, hi=0.
//  5. Pulse start again at cycle 10 of a running MULT -> ignored, single done. Start during
//     the done cycle -> new op accepted, done 34 cycles later.
//  6. Assert reset at cycle 15 of a DIV -> hi=lo=0, busy=0, no done. Fresh MULT 6x7
//     afterwards -> lo=42.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative signed multiply/divide engine.
package muldiv_pkg;

    localparam int MULDIV_WIDTH = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
// DIV packs {remainder, quotient} in acc; the new quotient bit is returned separately.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic                 op,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc_next,
    output logic                 q_bit
);

    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] diff_s;

    // Both candidate iterations are formed; op picks which one advances the accumulator.
    always_comb begin
        sum_s     = {1'b0, acc[2*WIDTH-1:WIDTH]}
                  + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        shifted_s = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff_s    = shifted_s - {1'b0, operand};
        acc_next  = acc;
        q_bit     = 1'b0;
        if (op == OP_DIV) begin
            // A borrow out of the trial subtraction means restore the shifted remainder.
            q_bit    = ~diff_s[WIDTH];
            acc_next = {(diff_s[WIDTH] ? shifted_s[WIDTH-1:0] : diff_s[WIDTH-1:0]),
                        acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_next = {sum_s, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative signed MULT/DIV sequencer with HI/LO result registers.
// Works on magnitudes for WIDTH steps, then restores signs in FINISH.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0]   ZERO_W  = {WIDTH{1'b0}};
    localparam logic [2*WIDTH-1:0] ZERO_2W = {(2*WIDTH){1'b0}};

    state_t               state_r, state_s;
    logic [CNT_W-1:0]     cnt_r, cnt_s;
    logic                 op_r, op_s;
    logic                 sign_a_r, sign_a_s;
    logic                 sign_b_r, sign_b_s;
    logic [WIDTH-1:0]     opnd_r, opnd_s;
    logic [2*WIDTH-1:0]   acc_r, acc_s;
    logic [WIDTH-1:0]     hi_r, hi_s;
    logic [WIDTH-1:0]     lo_r, lo_s;
    logic                 done_r, done_s;
    logic                 div_zero_r, div_zero_s;
    logic                 busy_r, busy_s;

    logic [WIDTH-1:0]     abs_a_s, abs_b_s;
    logic [2*WIDTH-1:0]   step_acc_s;
    logic                 q_bit_s;
    logic [2*WIDTH-1:0]   prod_s;
    logic [WIDTH-1:0]     quot_s, rem_s;

    // Magnitude of -2^(W-1) wraps to 2^(W-1), which is exact when read as unsigned.
    assign abs_a_s = operand_a[WIDTH-1] ? (ZERO_W - operand_a) : operand_a;
    assign abs_b_s = operand_b[WIDTH-1] ? (ZERO_W - operand_b) : operand_b;

    assign prod_s = (sign_a_r ^ sign_b_r) ? (ZERO_2W - acc_r) : acc_r;
    assign quot_s = (sign_a_r ^ sign_b_r) ? (ZERO_W - acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
    assign rem_s  = sign_a_r ? (ZERO_W - acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .op       (op_r),
        .acc      (acc_r),
        .operand  (opnd_r),
        .acc_next (step_acc_s),
        .q_bit    (q_bit_s)
    );

    // Next-state, datapath and output decode for the IDLE/RUN/FINISH sequencer.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        op_s       = op_r;
        sign_a_s   = sign_a_r;
        sign_b_s   = sign_b_r;
        opnd_s     = opnd_r;
        acc_s      = acc_r;
        hi_s       = hi_r;
        lo_s       = lo_r;
        done_s     = 1'b0;
        div_zero_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && (op == OP_DIV) && (operand_b == ZERO_W)) begin
                    done_s     = 1'b1;
                    div_zero_s = 1'b1;
                end else if (start) begin
                    state_s  = RUN;
                    cnt_s    = CNT_W'(WIDTH - 1);
                    op_s     = op;
                    sign_a_s = operand_a[WIDTH-1];
                    sign_b_s = operand_b[WIDTH-1];
                    if (op == OP_DIV) begin
                        acc_s  = {ZERO_W, abs_a_s};
                        opnd_s = abs_b_s;
                    end else begin
                        acc_s  = {ZERO_W, abs_b_s};
                        opnd_s = abs_a_s;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                acc_s = {step_acc_s[2*WIDTH-1:1], step_acc_s[0] | q_bit_s};
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_s = FINISH;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            FINISH: begin
                state_s = IDLE;
                done_s  = 1'b1;
                if (op_r == OP_DIV) begin
                    hi_s = rem_s;
                    lo_s = quot_s;
                end else begin
                    hi_s = prod_s[2*WIDTH-1:WIDTH];
                    lo_s = prod_s[WIDTH-1:0];
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State, datapath and registered outputs; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            op_r       <= OP_MULT;
            sign_a_r   <= 1'b0;
            sign_b_r   <= 1'b0;
            opnd_r     <= ZERO_W;
            acc_r      <= ZERO_2W;
            hi_r       <= ZERO_W;
            lo_r       <= ZERO_W;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            op_r       <= op_s;
            sign_a_r   <= sign_a_s;
            sign_b_r   <= sign_b_s;
            opnd_r     <= opnd_s;
            acc_r      <= acc_s;
            hi_r       <= hi_s;
            lo_r       <= lo_s;
            done_r     <= done_s;
            div_zero_r <= div_zero_s;
            busy_r     <= busy_s;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign div_zero = div_zero_r;
    assign hi       = hi_r;
    assign lo       = lo_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed, table-driven bench for muldiv_sequencer plus hand-written
// sequences for start-while-busy, back-to-back and mid-operation reset.
module tb_muldiv_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp;
    int n_fail;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dz;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Caller is at a negedge. Returns at the negedge where done is seen (or timeout).
    task automatic run_op(input logic op_i, input logic [31:0] a, input logic [31:0] b,
                          input int poke, output int lat, output int busy_cnt,
                          output logic [31:0] hi_o, output logic [31:0] lo_o,
                          output logic dz_o);
        start = 1'b1; op = op_i; operand_a = a; operand_b = b;
        @(posedge clk);
        #1;
        start = 1'b0; op = ~op_i; operand_a = ~a; operand_b = b + 32'd1;
        lat = 1;
        busy_cnt = 0;
        while (1'b1) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done || lat >= 200) break;
            if (lat == poke) begin
                start = 1'b1; op = 1'b1; operand_a = 32'd5; operand_b = 32'd0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            lat++;
        end
        start = 1'b0;
        hi_o = hi; lo_o = lo; dz_o = div_zero;
    endtask

    vec_t vecs[13];
    int lat, bcnt, extra_done;
    logic [31:0] r_hi, r_lo;
    logic r_dz;

    initial begin
        n_cmp = 0; n_fail = 0;
        vecs[0]  = '{1'b0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34};
        vecs[1]  = '{1'b1, 32'hFFFF_FFEF,  32'd5,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 34};
        vecs[2]  = '{1'b0, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 34};
        vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 34};
        vecs[4]  = '{1'b0, 32'h1234_5678,  32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0, 34};
        vecs[5]  = '{1'b1, 32'd100,        32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, 1'b0, 34};
        vecs[6]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 34};
        vecs[7]  = '{1'b1, 32'd17,         32'd17,        32'h0000_0000, 32'h0000_0001, 1'b0, 34};
        vecs[8]  = '{1'b1, 32'd5,          32'd17,        32'h0000_0005, 32'h0000_0000, 1'b0, 34};
        vecs[9]  = '{1'b0, 32'h0000_FFFF,  32'h0000_FFFF, 32'h0000_0000, 32'hFFFE_0001, 1'b0, 34};
        vecs[10] = '{1'b1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34};
        vecs[11] = '{1'b1, 32'h0ACF_1234,  32'h0000_2000, 32'h0000_1234, 32'h0000_5678, 1'b0, 34};
        // Divide by zero: done next cycle, hi/lo keep the previous result.
        vecs[12] = '{1'b1, 32'd9,          32'd0,         32'h0000_1234, 32'h0000_5678, 1'b1, 1};

        reset = 1'b1; start = 1'b0; op = 1'b0; operand_a = 32'd0; operand_b = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_dz", {63'd0, div_zero}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, lat, bcnt, r_hi, r_lo, r_dz);
            check($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].exp_lat));
            check($sformatf("v%0d_hi", i), {32'd0, r_hi}, {32'd0, vecs[i].exp_hi});
            check($sformatf("v%0d_lo", i), {32'd0, r_lo}, {32'd0, vecs[i].exp_lo});
            check($sformatf("v%0d_dz", i), {63'd0, r_dz}, {63'd0, vecs[i].exp_dz});
            if (i == 1) check("div_busy_cycles", 64'(bcnt), 64'd33);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("v%0d_single_done", i), {62'd0, done, div_zero}, 64'd0);
        end

        // Start pulsed (as a div-by-zero) mid-run must be ignored.
        run_op(1'b0, 32'd6, 32'd7, 10, lat, bcnt, r_hi, r_lo, r_dz);
        check("poke_lat", 64'(lat), 64'd34);
        check("poke_result", {r_hi, r_lo}, 64'd42);
        check("poke_dz", {63'd0, r_dz}, 64'd0);
        // Start in the done cycle is accepted.
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, -1, lat, bcnt, r_hi, r_lo, r_dz);
        check("b2b_lat", 64'(lat), 64'd34);
        check("b2b_result", {r_hi, r_lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        extra_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) extra_done++;
        end
        check("b2b_no_extra_done", 64'(extra_done), 64'd0);

        // Reset at cycle 15 of a DIV aborts it without a done.
        start = 1'b1; op = 1'b1; operand_a = 32'd1000; operand_b = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (14) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_hilo", {hi, lo}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        extra_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) extra_done++;
        end
        check("abort_no_done", 64'(extra_done), 64'd0);
        run_op(1'b0, 32'd6, 32'd7, -1, lat, bcnt, r_hi, r_lo, r_dz);
        check("post_reset_lat", 64'(lat), 64'd34);
        check("post_reset_result", {r_hi, r_lo}, 64'd42);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
